// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: read-mode selectors and a
// helper that derives the registered level flags from a word count.
package fifo_pkg;

    localparam int unsigned SHOWAHEAD_OFF = 0;
    localparam int unsigned SHOWAHEAD_ON  = 1;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_flags_t;

    // Level flags for a given fill count; the pulse flags are left clear for the caller.
    function automatic fifo_flags_t level_flags(input int unsigned used,
                                                input int unsigned depth,
                                                input int unsigned afull_lvl,
                                                input int unsigned aempty_lvl);
        fifo_flags_t f;
        f.empty        = (used == 0);
        f.full         = (used == depth);
        f.almost_empty = (used < aempty_lvl);
        f.almost_full  = (used >= afull_lvl);
        f.overflow     = 1'b0;
        f.underflow    = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/sc_fifo_if.sv
// Producer/consumer bundle for sc_fifo; master is the user side, slave is the FIFO.
interface sc_fifo_if #(
    parameter int unsigned kuan    = 16,
    parameter int unsigned shenbit = 11
);

    logic [kuan-1:0]  data;
    logic             wrreq;
    logic             rdreq;
    logic [kuan-1:0]  q;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [shenbit:0] usedw;
    logic             overflow;
    logic             underflow;

    modport master (
        output data, wrreq, rdreq,
        input  q, empty, full, almost_empty, almost_full, usedw, overflow, underflow
    );

    modport slave (
        input  data, wrreq, rdreq,
        output q, empty, full, almost_empty, almost_full, usedw, overflow, underflow
    );

endinterface

// File: rtl/sc_fifo_ram.sv
// Simple dual-port storage: one write port, one enabled registered read port.
// Read-during-write to the same address returns the old word.
module sc_fifo_ram #(
    parameter int unsigned kuan    = 16,
    parameter int unsigned shenbit = 11
) (
    input  logic               clock,
    input  logic               we,
    input  logic [shenbit-1:0] wr_addr,
    input  logic [kuan-1:0]    wr_data,
    input  logic               re,
    input  logic [shenbit-1:0] rd_addr,
    output logic [kuan-1:0]    rd_data
);

    logic [kuan-1:0] mem [2**shenbit];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sc_fifo.sv
// Single-clock FIFO using all 2**shenbit slots, with optional show-ahead output,
// programmable almost flags and one-cycle overflow/underflow pulses.
module sc_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned kuan       = 16,
    parameter int unsigned shenbit    = 11,
    parameter int unsigned showahead  = SHOWAHEAD_OFF,
    parameter int unsigned afull_lvl  = (1 << shenbit) - 4,
    parameter int unsigned aempty_lvl = 4
) (
    input logic      clock,
    input logic      sclr,
    sc_fifo_if.slave bus
);

    localparam int unsigned shen = 1 << shenbit;

    typedef logic [shenbit-1:0] ptr_t;
    typedef logic [shenbit:0]   cnt_t;

    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    cnt_t        usedw_q, usedw_d;
    fifo_flags_t flags_q, flags_d;
    logic        rd_ok, wr_ok;

    logic            ram_re;
    ptr_t            ram_raddr;
    logic [kuan-1:0] ram_rdata;
    logic            byp_hit;
    logic            byp_sel_q;
    logic [kuan-1:0] byp_data_q;
    logic            q_zero_q;

    always_comb begin
        rd_ok    = bus.rdreq & ~flags_q.empty;
        wr_ok    = bus.wrreq & (~flags_q.full | rd_ok);
        wr_ptr_d = wr_ptr_q + ptr_t'(wr_ok);
        rd_ptr_d = rd_ptr_q + ptr_t'(rd_ok);
        usedw_d  = usedw_q + cnt_t'(wr_ok) - cnt_t'(rd_ok);

        flags_d           = level_flags(32'(usedw_d), shen, afull_lvl, aempty_lvl);
        flags_d.overflow  = bus.wrreq & ~wr_ok;
        flags_d.underflow = bus.rdreq & ~rd_ok;
    end

    if (showahead == SHOWAHEAD_ON) begin : g_show
        // Prefetch the next head every cycle it will exist; a head that is being
        // written right now is not in the RAM yet, so it is captured from the bus.
        assign ram_re    = ~sclr & (usedw_d != '0);
        assign ram_raddr = rd_ptr_d;
        assign byp_hit   = wr_ok & (rd_ptr_d == wr_ptr_q);
    end else begin : g_norm
        assign ram_re    = ~sclr & rd_ok;
        assign ram_raddr = rd_ptr_q;
        assign byp_hit   = 1'b0;
    end

    sc_fifo_ram #(
        .kuan    (kuan),
        .shenbit (shenbit)
    ) u_ram (
        .clock   (clock),
        .we      (wr_ok & ~sclr),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.data),
        .re      (ram_re),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (sclr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            usedw_q    <= '0;
            flags_q    <= level_flags(0, shen, afull_lvl, aempty_lvl);
            byp_sel_q  <= 1'b0;
            byp_data_q <= '0;
            q_zero_q   <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
            flags_q  <= flags_d;
            // Output holds whenever the read port is idle, including while empty.
            if (ram_re) begin
                byp_sel_q  <= byp_hit;
                byp_data_q <= bus.data;
                q_zero_q   <= 1'b0;
            end
        end
    end

    // RAM output register has no reset, so q is forced to zero until first load.
    assign bus.q            = q_zero_q ? '0 : (byp_sel_q ? byp_data_q : ram_rdata);
    assign bus.usedw        = usedw_q;
    assign bus.empty        = flags_q.empty;
    assign bus.full         = flags_q.full;
    assign bus.almost_empty = flags_q.almost_empty;
    assign bus.almost_full  = flags_q.almost_full;
    assign bus.overflow     = flags_q.overflow;
    assign bus.underflow    = flags_q.underflow;

endmodule

// File: tb/tb_sc_fifo.sv
// Drives a normal-mode and a show-ahead sc_fifo with identical stimulus and checks
// both against a queue-based reference model.
module tb_sc_fifo;
    import fifo_pkg::*;

    localparam int unsigned KW   = 16;
    localparam int unsigned SB   = 3;
    localparam int unsigned SHEN = 8;
    localparam int unsigned AF   = 4;
    localparam int unsigned AE   = 2;

    logic          clock = 1'b0;
    logic          sclr  = 1'b0;
    logic          wrreq = 1'b0;
    logic          rdreq = 1'b0;
    logic [KW-1:0] data  = '0;

    always #5 clock = ~clock;

    sc_fifo_if #(.kuan(KW), .shenbit(SB)) bus_n ();
    sc_fifo_if #(.kuan(KW), .shenbit(SB)) bus_s ();

    assign bus_n.data  = data;
    assign bus_n.wrreq = wrreq;
    assign bus_n.rdreq = rdreq;
    assign bus_s.data  = data;
    assign bus_s.wrreq = wrreq;
    assign bus_s.rdreq = rdreq;

    sc_fifo #(
        .kuan(KW), .shenbit(SB), .showahead(SHOWAHEAD_OFF), .afull_lvl(AF), .aempty_lvl(AE)
    ) u_norm (
        .clock (clock),
        .sclr  (sclr),
        .bus   (bus_n)
    );

    sc_fifo #(
        .kuan(KW), .shenbit(SB), .showahead(SHOWAHEAD_ON), .afull_lvl(AF), .aempty_lvl(AE)
    ) u_show (
        .clock (clock),
        .sclr  (sclr),
        .bus   (bus_s)
    );

    int unsigned   ncmp  = 0;
    int unsigned   nfail = 0;
    logic [KW-1:0] mq[$];
    logic [KW-1:0] qn_m = '0;
    logic [KW-1:0] qs_m = '0;
    logic          ov_m = 1'b0;
    logic          un_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, advance the model, then sample just after the edge.
    task automatic step(input logic s, input logic w, input logic r, input logic [KW-1:0] d);
        bit          rok, wok;
        int unsigned n;
        logic [5:0]  fexp;
        sclr  = s;
        wrreq = w;
        rdreq = r;
        data  = d;
        @(posedge clock);
        if (s) begin
            mq.delete();
            qn_m = '0;
            qs_m = '0;
            ov_m = 1'b0;
            un_m = 1'b0;
        end else begin
            rok  = r && (mq.size() > 0);
            wok  = w && ((mq.size() < SHEN) || rok);
            ov_m = w && !wok;
            un_m = r && !rok;
            if (rok) qn_m = mq.pop_front();
            if (wok) mq.push_back(d);
            if (mq.size() > 0) qs_m = mq[0];
        end
        #1;
        n    = mq.size();
        fexp = {n == 0, n == SHEN, n < AE, n >= AF, ov_m, un_m};
        check("usedw_n", 32'(bus_n.usedw), n);
        check("flags_n", 32'({bus_n.empty, bus_n.full, bus_n.almost_empty, bus_n.almost_full,
                              bus_n.overflow, bus_n.underflow}), 32'(fexp));
        check("q_n", 32'(bus_n.q), 32'(qn_m));
        check("usedw_s", 32'(bus_s.usedw), n);
        check("flags_s", 32'({bus_s.empty, bus_s.full, bus_s.almost_empty, bus_s.almost_full,
                              bus_s.overflow, bus_s.underflow}), 32'(fexp));
        check("q_s", 32'(bus_s.q), 32'(qs_m));
    endtask

    initial begin
        int unsigned wp, rp;

        // Reset, then fill 1..8 and push once more into the full FIFO.
        step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, KW'(i));
        step(1'b0, 1'b1, 1'b0, 16'h0009);
        step(1'b0, 1'b0, 1'b0, '0);

        // Drain in normal order, then one extra read for underflow.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b0, '0);

        // Show-ahead presents a word written into an empty FIFO without a read.
        step(1'b0, 1'b1, 1'b0, 16'hABCD);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, '0);

        // Sustained read+write while full, across pointer wrap.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, KW'(16'h0100 + i));
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, KW'(16'h0200 + i));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, '0);

        // Read+write on empty: write lands, read rejected.
        step(1'b0, 1'b1, 1'b1, 16'h5555);
        step(1'b0, 1'b0, 1'b1, '0);

        // Reset mid-stream beats a concurrent write.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, KW'(16'h0300 + i));
        step(1'b1, 1'b1, 1'b0, 16'h7777);
        step(1'b0, 1'b0, 1'b0, '0);

        // Randomized phases with varying fill pressure and rare resets.
        for (int i = 0; i < 3000; i++) begin
            case (i / 500)
                0:       begin wp = 70; rp = 30; end
                1:       begin wp = 30; rp = 70; end
                2:       begin wp = 50; rp = 50; end
                3:       begin wp = 90; rp = 90; end
                4:       begin wp = 95; rp = 20; end
                default: begin wp = 10; rp = 95; end
            endcase
            step($urandom_range(299) == 0, $urandom_range(99) < wp, $urandom_range(99) < rp,
                 KW'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/sc_fifo.md
# sc_fifo

Single-clock, parametrised FIFO; successor to the dual-clock `fif` block for paths where producer and consumer share one clock. Holds the full 2**shenbit words, with no sacrificed slot. Adds a show-ahead read mode, programmable almost-full/almost-empty thresholds, and overflow/underflow pulses. Sits between same-clock pipeline stages, for example sample capture into a downstream packer.

## Interface
- `kuan`, 16, data width in bits
- `shenbit`, 11, log2 of depth; depth `shen` = 2**shenbit words
- `showahead`, 0, 0 = normal read (q valid one cycle after rdreq); 1 = q presents the head word while not empty
- `afull_lvl`, shen-4, almost_full asserts when usedw >= afull_lvl; legal range 1..shen
- `aempty_lvl`, 4, almost_empty asserts when usedw < aempty_lvl; legal range 1..shen

Ports:
- `clock` in 1: single clock, rising edge
- `sclr` in 1: synchronous reset, active-high
- `data` in kuan: write data
- `wrreq` in 1: write request
- `rdreq` in 1: read request / head acknowledge
- `q` out kuan: read data
- `empty` out 1: no stored words
- `full` out 1: usedw == shen
- `almost_empty` out 1: usedw < aempty_lvl
- `almost_full` out 1: usedw >= afull_lvl
- `usedw` out shenbit+1: stored word count, 0..shen
- `overflow` out 1: one-cycle pulse, write rejected
- `underflow` out 1: one-cycle pulse, read rejected

## Operation
- Reset: `sclr`=1 at a rising edge clears pointers, usedw=0, empty=1, full=0, almost_empty=1 (aempty_lvl>=1), almost_full=0, q=0, overflow=0, underflow=0. RAM contents are not cleared. `sclr` wins over wrreq/rdreq in the same cycle, and a reset mid-stream discards all stored words.
- Read accept: rd_ok = rdreq & ~empty.
- Write accept: wr_ok = wrreq & (~full | rd_ok). When full, a write is accepted only together with an accepted read.
- Empty + simultaneous wrreq/rdreq: the write is accepted, the read is rejected (underflow pulses), and there is no bypass to the read side.
- Rejected write: no state change, overflow=1 next cycle. Rejected read: no pointer change, q unchanged, underflow=1 next cycle.
- Pointers are shenbit wide and wrap naturally from shen-1 to 0. usedw is next-state: usedw + wr_ok - rd_ok.
- All flags are registered and derived from the next usedw, so they are consistent with usedw every cycle.
- Normal mode (showahead=0): on rd_ok, q loads mem[rd_ptr] at the next edge; otherwise q holds.
- Show-ahead mode (showahead=1): whenever empty=0, q equals the head word. rdreq acts as an acknowledge that advances q to the next word at the edge. When empty=1, q holds its last value.

## Timing
- Write to status: data written at edge N gives usedw/empty/full updated after edge N (visible in cycle N+1).
- Normal read latency: 1 cycle from the rd_ok edge to q.
- Show-ahead: a write into an empty FIFO at edge N has q = that data and empty=0 in cycle N+1. This requires a write-to-q bypass when the written address equals the head address.
- Back-to-back reads and writes sustain 1 word/cycle each, concurrently, at any fill level, including full and empty boundaries as defined above.
- overflow/underflow are high for exactly one cycle per rejected request.

## Structure
- Shared package `fifo_pkg`: constants `SHOWAHEAD_OFF`=0 and `SHOWAHEAD_ON`=1.
- Sub-module `sc_fifo_ram`: simple dual-port RAM, one write port, one registered read port, parametrised kuan/shenbit; inferable as block RAM.
- Top level holds the pointers, count, flags, and show-ahead prefetch/bypass logic.

## Test plan
- Reset then fill: shenbit=3, write 0x0001..0x0008 with no reads. Expect usedw 1..8, full=1 after the 8th write, and almost_full=1 once usedw>=4 (afull_lvl=4). A 9th wrreq gives overflow pulse, usedw stays 8.
- Drain, normal mode: from full, rdreq for 8 cycles. q=0x0001..0x0008, each one cycle after its rdreq; empty=1 after the 8th. A 9th rdreq gives an underflow pulse with q still 0x0008.
- Show-ahead: write 0xABCD into empty. Next cycle empty=0 and q=0xABCD without rdreq; one rdreq then gives empty=1.
- Simultaneous at full: full FIFO with wrreq=rdreq=1 for 20 cycles. usedw stays 8, no overflow, and output order is preserved across pointer wrap.
- Simultaneous at empty: wrreq=rdreq=1 with data 0x5555. Underflow pulse, usedw=1, and a following rdreq returns 0x5555.
- Mid-stream reset: usedw=5, assert sclr together with wrreq. Next cycle usedw=0, empty=1, q=0, and the write is discarded.
